// File: rtl/rgu_pixel_scheduler.sv
// rtl/rgu_pixel_scheduler.sv - frame sequencer that loads pixel X/Y into the RGU and runs its program per pixel
module rgu_pixel_scheduler #(
  parameter int         DATA_W           = 32,
  parameter int         RES_W            = 16,
  parameter logic [4:0] REG_X_ADDR       = 5'd0,
  parameter logic [4:0] REG_Y_ADDR       = 5'd1,
  parameter int         PROG_LEN         = 27,
  parameter int         DRAIN_CYC        = 2,
  parameter int         PUSHES_PER_PIXEL = 3
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iStart,
  input  logic [RES_W-1:0]  iResX,
  input  logic [RES_W-1:0]  iResY,
  input  logic [7:0]        iFifoFreeSlots,
  input  logic              iRguFifoPush,
  output logic              oRguEnable,
  output logic              oRguUartSelected,
  output logic              oRguUartWrite,
  output logic [7:0]        oRguUartAddr,
  output logic [DATA_W-1:0] oRguUartData,
  output logic [RES_W-1:0]  oPixelX,
  output logic [RES_W-1:0]  oPixelY,
  output logic              oBusy,
  output logic              oDone,
  output logic              oError
);

  // One counter serves both the RUN window and the DRAIN window, so size it for the longer one.
  localparam int CYC_W = (PROG_LEN > DRAIN_CYC) ? $clog2(PROG_LEN + 1) : $clog2(DRAIN_CYC + 1);

  localparam logic [CYC_W-1:0] RUN_LAST   = CYC_W'(PROG_LEN - 1);
  localparam logic [CYC_W-1:0] DRAIN_LAST = CYC_W'(DRAIN_CYC - 1);
  localparam logic [7:0]       PUSH_EXP   = 8'(PUSHES_PER_PIXEL);
  localparam logic [7:0]       PUSH_MAX   = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_X,
    S_LOAD_Y,
    S_WAIT_SPACE,
    S_RUN,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [RES_W-1:0]   res_x_q, res_x_d;
  logic [RES_W-1:0]   res_y_q, res_y_d;
  logic [RES_W-1:0]   x_q, x_d;
  logic [RES_W-1:0]   y_q, y_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [7:0]         push_q, push_d;
  logic               error_q, error_d;

  logic               last_x;
  logic               last_y;
  logic               counting;

  assign last_x   = (x_q == res_x_q - RES_W'(1));
  assign last_y   = (y_q == res_y_q - RES_W'(1));
  // Pushes that arrive while the program runs or while the pipeline drains belong to this pixel.
  assign counting = (state_q == S_RUN) || (state_q == S_DRAIN);

  // State and datapath registers; reset returns to IDLE with every counter and flag cleared.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= S_IDLE;
      res_x_q <= '0;
      res_y_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cyc_q   <= '0;
      push_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_x_q <= res_x_d;
      res_y_q <= res_y_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cyc_q   <= cyc_d;
      push_q  <= push_d;
      error_q <= error_d;
    end
  end

  // Next-state logic: frame setup, per-pixel load/run/drain sequence and raster advance.
  always_comb begin
    state_d = state_q;
    res_x_d = res_x_q;
    res_y_d = res_y_q;
    x_d     = x_q;
    y_d     = y_q;
    cyc_d   = cyc_q;
    push_d  = push_q;
    error_d = error_q;

    if (counting && iRguFifoPush && (push_q != PUSH_MAX)) begin
      push_d = push_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          res_x_d = iResX;
          res_y_d = iResY;
          x_d     = '0;
          y_d     = '0;
          error_d = 1'b0;
          if ((iResX == '0) || (iResY == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD_X;
          end
        end
      end

      S_LOAD_X: begin
        state_d = S_LOAD_Y;
      end

      S_LOAD_Y: begin
        state_d = S_WAIT_SPACE;
      end

      // The RGU cannot be stalled once enabled, so room for every push is reserved up front.
      S_WAIT_SPACE: begin
        if (iFifoFreeSlots >= PUSH_EXP) begin
          cyc_d   = '0;
          push_d  = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (cyc_q == RUN_LAST) begin
          cyc_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      S_DRAIN: begin
        if (cyc_q == DRAIN_LAST) begin
          cyc_d   = '0;
          state_d = S_NEXT;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      // A wrong push count is flagged but the frame keeps going.
      S_NEXT: begin
        if (push_q != PUSH_EXP) begin
          error_d = 1'b1;
        end
        if (last_x) begin
          x_d = '0;
          if (last_y) begin
            state_d = S_DONE;
          end else begin
            y_d     = y_q + RES_W'(1);
            state_d = S_LOAD_X;
          end
        end else begin
          x_d     = x_q + RES_W'(1);
          state_d = S_LOAD_X;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode straight from the registered state so they are all quiet in IDLE.
  always_comb begin
    oRguEnable       = 1'b0;
    oRguUartSelected = 1'b0;
    oRguUartWrite    = 1'b0;
    oRguUartAddr     = 8'd0;
    oRguUartData     = '0;

    case (state_q)
      S_LOAD_X: begin
        oRguUartSelected = 1'b1;
        oRguUartWrite    = 1'b1;
        oRguUartAddr     = {3'b000, REG_X_ADDR};
        oRguUartData     = DATA_W'(x_q);
      end
      S_LOAD_Y: begin
        oRguUartSelected = 1'b1;
        oRguUartWrite    = 1'b1;
        oRguUartAddr     = {3'b000, REG_Y_ADDR};
        oRguUartData     = DATA_W'(y_q);
      end
      S_RUN: begin
        oRguEnable = 1'b1;
      end
      default: begin
        oRguEnable = 1'b0;
      end
    endcase
  end

  assign oPixelX = x_q;
  assign oPixelY = y_q;
  assign oBusy   = (state_q != S_IDLE);
  assign oDone   = (state_q == S_DONE);
  assign oError  = error_q;

endmodule

// File: tb/tb_rgu_pixel_scheduler.sv
// tb/tb_rgu_pixel_scheduler.sv - self-checking bench for rgu_pixel_scheduler
module tb_rgu_pixel_scheduler;

  localparam int PROG_LEN = 27;
  localparam int PER_PIX  = 33;

  logic        clk = 1'b0;
  logic        iReset;
  logic        iStart;
  logic [15:0] iResX;
  logic [15:0] iResY;
  logic [7:0]  iFifoFreeSlots;
  logic        iRguFifoPush;
  logic        oRguEnable;
  logic        oRguUartSelected;
  logic        oRguUartWrite;
  logic [7:0]  oRguUartAddr;
  logic [31:0] oRguUartData;
  logic [15:0] oPixelX;
  logic [15:0] oPixelY;
  logic        oBusy;
  logic        oDone;
  logic        oError;

  always #5 clk = ~clk;

  rgu_pixel_scheduler dut (
    .iClock           (clk),
    .iReset           (iReset),
    .iStart           (iStart),
    .iResX            (iResX),
    .iResY            (iResY),
    .iFifoFreeSlots   (iFifoFreeSlots),
    .iRguFifoPush     (iRguFifoPush),
    .oRguEnable       (oRguEnable),
    .oRguUartSelected (oRguUartSelected),
    .oRguUartWrite    (oRguUartWrite),
    .oRguUartAddr     (oRguUartAddr),
    .oRguUartData     (oRguUartData),
    .oPixelX          (oPixelX),
    .oPixelY          (oPixelY),
    .oBusy            (oBusy),
    .oDone            (oDone),
    .oError           (oError)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Observation log for the current frame.
  logic [39:0] q_wr[$];
  logic [31:0] q_xy[$];
  int          q_len[$];
  int          cyc       = 0;
  int          first_lx  = -1;
  int          done_cnt  = 0;
  int          done_cyc  = 0;
  int          viol      = 0;
  int          run_len   = 0;
  int          run_idx   = 0;
  int          rcyc      = 0;
  int          cur_n     = 3;
  int          bad_idx   = -1;
  int          bad_n     = 3;
  logic        err_at_done = 1'b0;
  logic        en_prev   = 1'b0;
  bit          rand_free = 1'b0;
  logic [7:0]  fix_free  = 8'd16;
  logic [7:0]  rnd_free  = 8'd16;

  assign iFifoFreeSlots = rand_free ? rnd_free : fix_free;

  // RGU stand-in plus protocol monitor, evaluated on the falling edge.
  initial begin
    iRguFifoPush = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (oRguUartSelected) begin
        q_wr.push_back({oRguUartAddr, oRguUartData});
        if (first_lx < 0 && oRguUartAddr == 8'd0) first_lx = cyc;
      end else if (oRguUartWrite || oRguUartAddr != 8'd0 || oRguUartData != 32'd0) begin
        viol++;
      end
      if (oRguUartSelected != oRguUartWrite) viol++;
      if (oRguEnable && oRguUartSelected) viol++;
      if (oRguEnable && !oBusy) viol++;
      if (oRguEnable && !en_prev) begin
        q_xy.push_back({oPixelX, oPixelY});
        if (iFifoFreeSlots < 8'd3) viol++;
        run_len = 0;
        rcyc    = 1;
        cur_n   = (run_idx == bad_idx) ? bad_n : 3;
        run_idx++;
      end else if (rcyc != 0 && rcyc < 29) begin
        rcyc++;
      end else begin
        rcyc = 0;
      end
      if (oRguEnable) run_len++;
      if (!oRguEnable && en_prev) q_len.push_back(run_len);
      if (oDone) begin
        done_cnt++;
        done_cyc    = cyc;
        err_at_done = oError;
      end
      iRguFifoPush = (rcyc == 8  && cur_n >= 1) || (rcyc == 20 && cur_n >= 2) ||
                     (rcyc == 28 && cur_n >= 3) || (rcyc == 29 && cur_n >= 4);
      en_prev = oRguEnable;
      if (rand_free) rnd_free = 8'($urandom_range(0, 8));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    q_wr.delete();
    q_xy.delete();
    q_len.delete();
    first_lx = -1;
    done_cnt = 0;
    viol     = 0;
    run_idx  = 0;
  endtask

  // Run one frame and compare everything seen with the raster-order reference.
  task automatic run_frame(input int w, input int h, input int bi, input int bn,
                           input bit chk_lat, input bit extra_start);
    int  n;
    int  k;
    int  idx;
    bit  exp_err;
    n       = w * h;
    exp_err = (bi >= 0) && (bi < n) && (bn != 3);
    mon_clear();
    bad_idx = bi;
    bad_n   = bn;
    step();
    iResX  = 16'(w);
    iResY  = 16'(h);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    iResX  = 16'($urandom_range(1, 5));
    iResY  = 16'($urandom_range(1, 5));
    k = 0;
    while (done_cnt == 0 && k < 6000) begin
      step();
      k++;
      iStart = extra_start && (k == 10);
    end
    iStart = 1'b0;
    chk("frame_timeout", 64'(k < 6000), 64'd1);
    step();
    step();
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("busy_after", 64'(oBusy), 64'd0);
    chk("err_at_done", 64'(err_at_done), 64'(exp_err));
    chk("err_sticky", 64'(oError), 64'(exp_err));
    chk("protocol", 64'(viol), 64'd0);
    chk("run_count", 64'(q_xy.size()), 64'(n));
    chk("write_count", 64'(q_wr.size()), 64'(2 * n));
    chk("len_count", 64'(q_len.size()), 64'(n));
    if (q_xy.size() == n && q_wr.size() == 2 * n && q_len.size() == n) begin
      for (int y = 0; y < h; y++) begin
        for (int x = 0; x < w; x++) begin
          idx = y * w + x;
          chk("run_xy", 64'(q_xy[idx]), 64'({16'(x), 16'(y)}));
          chk("wr_x", 64'(q_wr[2 * idx]), 64'({8'h00, 32'(x)}));
          chk("wr_y", 64'(q_wr[2 * idx + 1]), 64'({8'h01, 32'(y)}));
          chk("run_len", 64'(q_len[idx]), 64'(PROG_LEN));
        end
      end
    end
    if (chk_lat) chk("latency", 64'(done_cyc - first_lx), 64'(PER_PIX * n));
  endtask

  initial begin
    int enc;
    int k;
    iReset = 1'b1;
    iStart = 1'b0;
    iResX  = 16'd0;
    iResY  = 16'd0;
    repeat (3) step();
    iReset = 1'b0;
    step();

    chk("rst_busy", 64'(oBusy), 64'd0);
    chk("rst_done", 64'(oDone), 64'd0);
    chk("rst_error", 64'(oError), 64'd0);
    chk("rst_enable", 64'(oRguEnable), 64'd0);
    chk("rst_uart", 64'({oRguUartSelected, oRguUartWrite, oRguUartAddr, oRguUartData}), 64'd0);
    chk("rst_pixel", 64'({oPixelX, oPixelY}), 64'd0);

    // 1x1 frame with ample space: exact latency.
    fix_free = 8'd16;
    run_frame(1, 1, -1, 3, 1'b1, 1'b0);

    // 3x2 frame with a second start pulse mid-frame that must be ignored.
    run_frame(3, 2, -1, 3, 1'b1, 1'b1);

    // Space gating: held at 2, run starts the cycle after 3 is seen.
    mon_clear();
    fix_free = 8'd2;
    iResX  = 16'd1;
    iResY  = 16'd1;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    enc = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (oRguEnable) enc++;
    end
    chk("wait_no_enable", 64'(enc), 64'd0);
    chk("wait_busy", 64'(oBusy), 64'd1);
    fix_free = 8'd3;
    step();
    chk("wait_enable_after", 64'(oRguEnable), 64'd1);
    k = 0;
    while (done_cnt == 0 && k < 200) begin
      step();
      k++;
    end
    chk("wait_done", 64'(done_cnt), 64'd1);
    chk("wait_protocol", 64'(viol), 64'd0);
    fix_free = 8'd16;

    // Short push count on the second pixel of a 2x1 frame.
    run_frame(2, 1, 1, 2, 1'b1, 1'b0);

    // Zero width: straight to DONE, nothing written, nothing run.
    mon_clear();
    iResX  = 16'd0;
    iResY  = 16'd5;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    chk("zero_done", 64'(oDone), 64'd1);
    chk("zero_busy", 64'(oBusy), 64'd1);
    step();
    chk("zero_done_end", 64'(oDone), 64'd0);
    chk("zero_idle", 64'(oBusy), 64'd0);
    repeat (3) step();
    chk("zero_writes", 64'(q_wr.size()), 64'd0);
    chk("zero_runs", 64'(q_xy.size()), 64'd0);

    // Randomized frames, random space, random push faults and stray starts.
    rand_free = 1'b1;
    for (int f = 0; f < 6; f++) begin
      int w;
      int h;
      w = $urandom_range(1, 3);
      h = $urandom_range(1, 3);
      run_frame(w, h, $urandom_range(0, w * h + 1), $urandom_range(0, 4), 1'b0, 1'($urandom_range(0, 1)));
    end
    rand_free = 1'b0;
    fix_free  = 8'd16;

    // Reset in the middle of a run after an error was already flagged.
    mon_clear();
    bad_idx = 0;
    bad_n   = 0;
    step();
    iResX  = 16'd2;
    iResY  = 16'd2;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    k = 0;
    while (oError == 1'b0 && k < 200) begin
      step();
      k++;
    end
    chk("rst_err_seen", 64'(oError), 64'd1);
    enc = 0;
    k = 0;
    while (enc < 10 && k < 200) begin
      step();
      k++;
      if (oRguEnable) enc++;
    end
    chk("rst_run10", 64'(enc), 64'd10);
    iReset = 1'b1;
    step();
    chk("midrst_enable", 64'(oRguEnable), 64'd0);
    chk("midrst_busy", 64'(oBusy), 64'd0);
    chk("midrst_error", 64'(oError), 64'd0);
    chk("midrst_pixel", 64'({oPixelX, oPixelY}), 64'd0);
    iReset = 1'b0;
    repeat (5) step();
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    chk("midrst_idle", 64'(oBusy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
